// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the ADC SPI sampler.
//   SAMPLE_W          - ADC word width
//   SHIFT_HALVES      - SCLK half-periods per word (two per bit)
//   DEF_CLK_DIV       - default SCLK half-period in clk cycles
//   DEF_SAMPLE_PERIOD - default clk cycles between conversion-start ticks
//   adc_state_e       - conversion FSM states
package adc_spi_pkg;

  localparam int SAMPLE_W          = 8;
  localparam int SHIFT_HALVES      = 2 * SAMPLE_W;
  localparam int DEF_CLK_DIV       = 2;
  localparam int DEF_SAMPLE_PERIOD = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_DONE
  } adc_state_e;

endpackage

// File: rtl/sample_timer.sv
// sample_timer: free-running conversion timer with start gating and
// overrun reporting.
//   clk, rst  - clock, synchronous active-high reset
//   en        - count enable; count is held at 0 while low
//   idle      - converter can accept a start this cycle
//   start     - tick accepted by an idle converter (combinational)
//   overrun   - registered one-cycle pulse after a tick that found the
//               converter busy
module sample_timer
  import adc_spi_pkg::*;
#(
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic idle,
  output logic start,
  output logic overrun
);

  localparam int CW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          tick;

  // Count sits at 0 while disabled, so re-enabling ticks immediately.
  assign tick  = en && !rst && (cnt == '0);
  assign start = tick && idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= tick && !idle;
      if (!en)
        cnt <= '0;
      else if (cnt == CW'(SAMPLE_PERIOD - 1))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler: periodically reads an 8-bit SPI ADC (MSB first).
//   clk, rst    - clock, synchronous active-high reset
//   en          - enables the sample timer
//   adc_miso    - serial data from the ADC
//   adc_cs_n    - chip select, active low, registered
//   adc_sclk    - serial clock, idle low, registered
//   data_out    - last completed sample, updated only in DONE
//   data_valid  - one-cycle strobe in DONE
//   busy        - FSM not idle
//   overrun     - one-cycle pulse after a dropped tick
module adc_spi_sampler
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                adc_miso,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                data_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(SHIFT_HALVES);

  adc_state_e          state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       half_q, half_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic [SAMPLE_W-1:0] dout_d;
  logic                sclk_d, cs_n_d, dv_d;
  logic                idle, start, div_end;

  assign idle    = (state_q == ST_IDLE);
  assign busy    = !idle;
  assign div_end = (div_q == DW'(CLK_DIV - 1));

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .idle   (idle),
    .start  (start),
    .overrun(overrun)
  );

  // Outputs are computed one cycle ahead and registered, so cs_n/sclk
  // change on the same edge as the state they belong to.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    sh_d    = sh_q;
    dout_d  = data_out;
    sclk_d  = adc_sclk;
    cs_n_d  = adc_cs_n;
    dv_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CS_SETUP;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          sh_d    = '0;
        end
      end
      ST_CS_SETUP: begin
        if (div_end) begin
          // First SCLK rise: sample the MSB on the way into SHIFT.
          state_d = ST_SHIFT;
          div_d   = '0;
          half_d  = '0;
          sclk_d  = 1'b1;
          sh_d    = {sh_q[SAMPLE_W-2:0], adc_miso};
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_end) begin
          div_d = '0;
          if (half_q == HW'(SHIFT_HALVES - 1)) begin
            // Last low half of the 8th bit has elapsed.
            state_d = ST_DONE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            dv_d    = 1'b1;
            dout_d  = sh_q;
          end else begin
            half_d = half_q + 1'b1;
            sclk_d = ~adc_sclk;
            if (!adc_sclk)
              sh_d = {sh_q[SAMPLE_W-2:0], adc_miso};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      half_q     <= '0;
      sh_q       <= '0;
      data_out   <= '0;
      adc_sclk   <= 1'b0;
      adc_cs_n   <= 1'b1;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      sh_q       <= sh_d;
      data_out   <= dout_d;
      adc_sclk   <= sclk_d;
      adc_cs_n   <= cs_n_d;
      data_valid <= dv_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// tb_adc_spi_sampler: two sampler instances (SAMPLE_PERIOD 64 and 20,
// CLK_DIV 2) driven by SPI ADC slave models, checked every cycle
// against a timeline model derived from the conversion latencies, plus
// literal checks on the logged strobe/chip-select/overrun history.
module tb_adc_spi_sampler;

  localparam int D    = 2;
  localparam int DONE = 17 * D + 1;  // cycle index of DONE after the tick

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, en0 = 1'b1, en1 = 1'b1;
  logic [1:0] miso = 2'b00;
  wire cs_n0, cs_n1, sclk0, sclk1, dv0, dv1, busy0, busy1, ov0, ov1;
  wire [7:0] dout0, dout1;

  adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(64)) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .adc_miso(miso[0]),
    .adc_cs_n(cs_n0), .adc_sclk(sclk0), .data_out(dout0),
    .data_valid(dv0), .busy(busy0), .overrun(ov0));

  adc_spi_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(20)) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .adc_miso(miso[1]),
    .adc_cs_n(cs_n1), .adc_sclk(sclk1), .data_out(dout1),
    .data_valid(dv1), .busy(busy1), .overrun(ov1));

  wire [1:0] rst_v  = {rst1, rst0};
  wire [1:0] en_v   = {en1, en0};
  wire [1:0] cs_v   = {cs_n1, cs_n0};
  wire [1:0] sclk_v = {sclk1, sclk0};
  wire [1:0] dv_v   = {dv1, dv0};
  wire [1:0] busy_v = {busy1, busy0};
  wire [1:0] ov_v   = {ov1, ov0};
  wire [7:0] dout_v [2];
  assign dout_v[0] = dout0;
  assign dout_v[1] = dout1;

  function automatic int per(input int u);
    return (u == 0) ? 64 : 20;
  endfunction

  logic [7:0] words [2][16];
  initial begin
    logic [7:0] w0 [11] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5A,
                            8'h3C, 8'hFF, 8'h00, 8'h77, 8'h88};
    for (int i = 0; i < 16; i++) begin
      words[0][i] = (i < 11) ? w0[i] : 8'hEE;
      words[1][i] = 8'h11 * (i + 1);
    end
  end

  int vec_cnt = 0, err_cnt = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  int   mcnt [2] = '{0, 0};
  int   mp   [2] = '{0, 0};
  int   midx [2] = '{0, 0};
  bit   mact [2] = '{0, 0};
  logic [7:0] mword [2];
  logic [7:0] e_dout [2] = '{8'h00, 8'h00};
  logic [1:0] e_cs = 2'b11, e_sclk = 2'b00, e_busy = 2'b00, e_dv = 2'b00, e_ov = 2'b00;

  always @(posedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      bit tick, pb;
      int j;
      if (rst_v[u]) begin
        mcnt[u] = 0; mact[u] = 0; mp[u] = 0; e_dout[u] = 8'h00; e_ov[u] = 1'b0;
      end else begin
        tick = en_v[u] && (mcnt[u] == 0);
        pb   = mact[u];
        if (mact[u]) begin
          mp[u]++;
          if (mp[u] > DONE) mact[u] = 0;
        end
        e_ov[u] = tick && pb;
        if (tick && !pb) begin
          mact[u] = 1; mp[u] = 1;
          mword[u] = words[u][midx[u] % 16];
          midx[u]++;
        end
        mcnt[u] = en_v[u] ? (mcnt[u] + 1) % per(u) : 0;
        if (mact[u] && mp[u] == DONE) e_dout[u] = mword[u];
      end
      j = mp[u] - 1 - D;
      e_busy[u] = mact[u];
      e_cs[u]   = !(mact[u] && mp[u] <= 17 * D);
      e_sclk[u] = mact[u] && j >= 0 && j < 16 * D && ((j / D) % 2 == 0);
      e_dv[u]   = mact[u] && mp[u] == DONE;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      vec_cnt++;
      if ({cs_v[u], sclk_v[u], busy_v[u], dv_v[u], ov_v[u], dout_v[u]} !==
          {e_cs[u], e_sclk[u], e_busy[u], e_dv[u], e_ov[u], e_dout[u]}) begin
        err_cnt++;
        $display("FAIL cycle u%0d cyc %0d: got cs_n/sclk/busy/dv/ov/dout=%b/%b/%b/%b/%b/%h expected %b/%b/%b/%b/%b/%h",
                 u, cyc, cs_v[u], sclk_v[u], busy_v[u], dv_v[u], ov_v[u], dout_v[u],
                 e_cs[u], e_sclk[u], e_busy[u], e_dv[u], e_ov[u], e_dout[u]);
      end
    end
  end

  // ---------------- ADC slaves + event log ----------------
  logic [1:0] pcs = 2'b11, psclk = 2'b00;
  logic [7:0] aword [2] = '{8'h00, 8'h00};
  int aidx [2] = '{0, 0};
  int arise [2] = '{0, 0};
  int st_cyc [2][32], st_val [2][32], st_rise [2][32], st_csn [2][32];
  int cf_cyc [2][32], ov_cyc [2][32];
  int st_n [2] = '{0, 0}, cf_n [2] = '{0, 0}, ov_n [2] = '{0, 0};

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!cs_v[u] && pcs[u]) begin
        aword[u] = words[u][aidx[u] % 16];
        aidx[u]++;
        arise[u] = 0;
        if (cf_n[u] < 32) cf_cyc[u][cf_n[u]] = cyc;
        cf_n[u]++;
      end
      if (sclk_v[u] && !psclk[u]) arise[u]++;
      miso[u] = (arise[u] < 8) ? aword[u][7 - arise[u]] : 1'b0;
      if (dv_v[u] && st_n[u] < 32) begin
        st_cyc[u][st_n[u]]  = cyc;
        st_val[u][st_n[u]]  = int'(dout_v[u]);
        st_rise[u][st_n[u]] = arise[u];
        st_csn[u][st_n[u]]  = int'(cs_v[u]);
        st_n[u]++;
      end
      if (ov_v[u] && ov_n[u] < 32) begin
        ov_cyc[u][ov_n[u]] = cyc;
        ov_n[u]++;
      end
      pcs[u]   = cs_v[u];
      psclk[u] = sclk_v[u];
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_dv(input int u, input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (!dv_v[u] && k < 300);
    if (!dv_v[u]) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s: got timeout expected strobe", nm);
    end
  endtask

  task automatic wait_cs(input int u, input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (cs_v[u] && k < 300);
    if (cs_v[u]) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s: got timeout expected cs_n fall", nm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cf_before;
    fork
      begin : unit0
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cs_n", cs_n0, 1); chk("reset_dout", dout0, 8'h00);
        chk("reset_busy", busy0, 0);
        @(posedge clk); #1 rst0 = 1'b0;
        for (int i = 0; i < 5; i++) wait_dv(0, "strobe_u0_a");
        wait_cs(0, "cs_fall_abort");
        repeat (11) @(posedge clk);
        #1 rst0 = 1'b1;
        @(posedge clk); #1 rst0 = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", cs_n0, 1); chk("abort_sclk", sclk0, 0);
        chk("abort_dv", dv0, 0);     chk("abort_dout", dout0, 8'h00);
        for (int i = 0; i < 3; i++) wait_dv(0, "strobe_u0_b");
        wait_cs(0, "cs_fall_endrop");
        repeat (6) @(posedge clk);
        #1 en0 = 1'b0;
        cf_before = cf_n[0];
        repeat (100) @(posedge clk);
        chk("endrop_strobe_cnt", st_n[0], 9);
        chk("endrop_no_cs_fall", cf_n[0], cf_before);
        #1 en0 = 1'b1;
        @(negedge clk); chk("reen_cs_same", cs_n0, 1);
        @(negedge clk); chk("reen_cs_next", cs_n0, 0);
        wait_dv(0, "strobe_u0_c");
      end
      begin : unit1
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;
        for (int i = 0; i < 3; i++) wait_dv(1, "strobe_u1");
        @(posedge clk); #1 en1 = 1'b0;
      end
    join
    repeat (5) @(posedge clk);

    // literal expectations on the logged history
    begin
      int exp_v [10] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04,
                         8'h3C, 8'hFF, 8'h00, 8'h77, 8'h88};
      chk("u0_strobe_count", st_n[0], 10);
      chk("u0_cs_fall_count", cf_n[0], 11);
      chk("u0_overruns", ov_n[0], 0);
      chk("u0_first_latency", st_cyc[0][0] - cf_cyc[0][0], 34);
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("u0_val%0d", i), st_val[0][i], exp_v[i]);
        chk($sformatf("u0_rises%0d", i), st_rise[0][i], 8);
        chk($sformatf("u0_cs_at_dv%0d", i), st_csn[0][i], 1);
      end
      for (int i = 1; i < 5; i++)
        chk($sformatf("u0_spacing%0d", i), st_cyc[0][i] - st_cyc[0][i-1], 64);
      chk("u1_strobe_count", st_n[1], 3);
      chk("u1_val0", st_val[1][0], 8'h11);
      chk("u1_val2", st_val[1][2], 8'h33);
      chk("u1_spacing1", st_cyc[1][1] - st_cyc[1][0], 40);
      chk("u1_spacing2", st_cyc[1][2] - st_cyc[1][1], 40);
      chk("u1_overruns", ov_n[1], 3);
      chk("u1_first_ov", ov_cyc[1][0] - cf_cyc[1][0], 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
